carrier_nco_mixer: RTL and testbench
====================================

# carrier_nco_mixer

Numerically controlled carrier oscillator and complex downconversion mixer for the GPS tracking channel. It consumes the loop filter's 32-bit `correction` word, advances a carrier phase accumulator once per input sample, and mixes each real IF sample into in-phase and quadrature baseband samples. Those samples feed the Costas loop's integrate-and-dump blocks. An epoch marker keeps the dump boundaries aligned with the samples produced here.

## Interface
- `PHASE_W`, 32: phase accumulator and frequency control word width.
- `LUT_ADDR_W`, 10: phase bits used to address the sine/cosine table; the top 2 bits select the quadrant.
- `LUT_W`, 16: signed sine/cosine amplitude width; full scale is 2^(LUT_W-1)-1.
- `NOMINAL_FCW`, 32'h4000_0000: nominal frequency control word, in phase units per sample.
- `EPOCH_LEN`, 10000: number of samples per integrate-and-dump epoch.
- `clk` in 1: sole clock; all logic is rising-edge.
- `rst` in 1: asynchronous reset, active-low.
- `sample_in` in 16: signed IF sample.
- `sample_valid` in 1: `sample_in` is accepted on this cycle.
- `correction` in 32: signed frequency correction from the loop filter.
- `correction_valid` in 1: single-cycle strobe that loads `correction`.
- `out_i` out 16: signed mixed in-phase sample.
- `out_q` out 16: signed mixed quadrature sample.
- `out_valid` out 1: `out_i`/`out_q` are valid on this cycle.
- `out_last` out 1: qualifies `out_valid`; marks the final sample of an epoch.

## Operation
- `fcw` register = `NOMINAL_FCW + correction`, modulo 2^PHASE_W.
  - Loaded on the cycle `correction_valid` is high.
  - Reset value is `NOMINAL_FCW`.
- Phase accumulator `phase`: on each accepted sample, `phase <= phase + fcw`, modulo 2^PHASE_W, wrapping silently.
  - The sample accepted on a cycle is mixed with the pre-increment `phase`.
  - With no sample accepted, `phase` holds.
- If `correction_valid` and `sample_valid` are high on the same cycle:
  - the current sample uses the old `fcw` for its increment;
  - the new `fcw` applies from the next accepted sample.
- Table address = `phase[PHASE_W-1 -: LUT_ADDR_W]`, truncated.
  - A quarter-wave table plus quadrant folding yields `cos` and `sin`.
  - Phase 0 gives cos = 2^(LUT_W-1)-1 and sin = 0.
- Mixing:
  - `out_i = (s*cos + 2^(LUT_W-2)) >>> (LUT_W-1)`
  - `out_q = (-(s*sin) + 2^(LUT_W-2)) >>> (LUT_W-1)`
  - Products are 32-bit signed. The result always fits in 16 bits, so no saturation is required.
- Epoch counter `ep_cnt`, range 0..EPOCH_LEN-1, counts accepted samples.
  - The sample accepted at `ep_cnt == EPOCH_LEN-1` is tagged last, and the counter wraps to 0.
  - The tag travels down the pipeline and appears as `out_last`.
- No backpressure exists: the output must be consumed when valid.

## Timing
- Pipeline stages:
  - S0 (input register): latch `sample_in` and the current `phase`; update `phase`.
  - S1: table lookup.
  - S2: multiply.
  - S3: round and register the outputs.
- Latency is 3 cycles from `sample_valid` to `out_valid`. Back-to-back samples are supported at one per cycle.
- `out_valid` and `out_last` are one-cycle pulses per sample; gaps in `sample_valid` pass through as gaps.
- Reset values:
  - `out_i`, `out_q`, `out_valid`, `out_last`: 0
  - `phase`, `ep_cnt`: 0
  - `fcw`: `NOMINAL_FCW`
- Reset asserted mid-stream clears all of the above immediately.
  - Samples in flight are discarded; no `out_valid` is produced for them.
  - The first sample after release starts at phase 0 and `ep_cnt` 0.

## Configuration
- `NCO_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to seed) advances on each accepted sample.
  - Its low `PHASE_W-LUT_ADDR_W` bits (zero-extended when that count exceeds 16) are added to `phase` before address truncation. `phase` itself is unaffected.
- `NCO_DITHER_EN` undefined: plain truncation, and no LFSR is instantiated.
- Latency is the same in both builds.

## Structure
- Package `nco_pkg` holds:
  - the default widths;
  - the quadrant enum (Q0..Q3);
  - the LFSR seed and tap constants;
  - the rounding-constant function.
- Sub-module `nco_sincos_lut` holds the quarter-wave ROM, quadrant folding and the S1 register.
  - It takes a `LUT_ADDR_W` address and returns registered signed `sin`/`cos` with 1-cycle latency.

## Test plan
All scenarios run with `NCO_DITHER_EN` undefined.
- Reset check: hold `rst` low, then release. Expect all outputs 0. After the first valid sample at phase 0, expect `fcw` = 32'h4000_0000.
- Quarter-cycle rotation: `NOMINAL_FCW` = 2^30, correction 0, `sample_in` = 1000 for 4 consecutive cycles.
  - Expect (I,Q) = (1000,0), (0,-1000), (-1000,0), (0,1000).
  - First `out_valid` appears 3 cycles after the first `sample_valid`.
- Rounding and extremes at phase 0:
  - `sample_in` = -32768 gives `out_i` = -32768, `out_q` = 0.
  - `sample_in` = 16384 gives `out_i` = 16384.
- Correction timing: `correction` = -2^30 with `correction_valid` on the same cycle as sample k.
  - Sample k+1 uses phase `phase_k + 2^30`.
  - Sample k+2 and later see zero increment, so `phase` stays constant.
- Epoch: `EPOCH_LEN` = 5, 12 samples with random `sample_valid` gaps. Expect `out_last` only on output samples 5 and 10.
- Mid-stream reset: assert `rst` while 2 samples are in flight.
  - Expect no `out_valid` for them.
  - The next sample after release is mixed at phase 0 and begins a fresh epoch.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared definitions for the carrier NCO / mixer: default widths, quadrant
// encoding, dither LFSR constants and the fixed-point helper functions.
// The NCO_DITHER_EN build option is used by carrier_nco_mixer and relies on
// the LFSR constants defined here.
package nco_pkg;

    localparam int          DEF_PHASE_W     = 32;
    localparam int          DEF_LUT_ADDR_W  = 10;
    localparam int          DEF_LUT_W       = 16;
    localparam logic [31:0] DEF_NOMINAL_FCW = 32'h4000_0000;
    localparam int          DEF_EPOCH_LEN   = 10000;

    // Top two table-address bits select one quarter of the carrier cycle.
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_e;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register:
    // feedback is the XOR of bits 0,2,3,5 and enters at bit 15.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // pi/2 in Q2.30, used only when building the quarter-wave table.
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    // Half an LSB of the product after dropping LUT_W-1 fraction bits.
    function automatic int round_const(input int lut_w);
        return 1 << (lut_w - 2);
    endfunction

    // Elaboration-time quarter-wave entry: round(amp * sin(pi/2 * k / n)).
    // Integer Taylor series in Q2.30; odd terms up to x^13 are well below
    // one LSB of a 16-bit table.
    function automatic int quarter_sine(input int k, input int n, input int amp);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint r;
        x    = (HALF_PI_Q30 * longint'(k)) / longint'(n);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int j = 1; j <= 6; j++) begin
            term = -((term * x2) >>> 30) / longint'((2 * j) * (2 * j + 1));
            acc  = acc + term;
        end
        r = (acc * longint'(amp) + (longint'(1) <<< 29)) >>> 30;
        if (r > longint'(amp)) r = longint'(amp);
        if (r < 0) r = 0;
        return int'(r);
    endfunction

endpackage

// File: rtl/nco_sincos_lut.sv
// Quarter-wave sine ROM with quadrant folding. Returns registered signed
// sin/cos for a LUT_ADDR_W phase address with one cycle of latency.
module nco_sincos_lut
    import nco_pkg::*;
#(
    parameter int LUT_ADDR_W = DEF_LUT_ADDR_W,
    parameter int LUT_W      = DEF_LUT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LUT_ADDR_W-1:0] addr,
    output logic [LUT_W-1:0]      sin,
    output logic [LUT_W-1:0]      cos
);

    localparam int IDX_W = LUT_ADDR_W - 2;
    localparam int QN    = 1 << IDX_W;
    localparam int AMP   = (1 << (LUT_W - 1)) - 1;

    // QN+1 entries so that both 0 and full scale are stored exactly.
    logic [LUT_W-1:0] rom [0:QN];

    for (genvar g = 0; g <= QN; g++) begin : g_rom
        localparam logic [LUT_W-1:0] ENTRY = LUT_W'(quarter_sine(g, QN, AMP));
        assign rom[g] = ENTRY;
    end

    quadrant_e               quad;
    logic [IDX_W:0]          fwd;
    logic [IDX_W:0]          rev;
    logic signed [LUT_W-1:0] mag_fwd;
    logic signed [LUT_W-1:0] mag_rev;
    logic signed [LUT_W-1:0] sin_d;
    logic signed [LUT_W-1:0] cos_d;

    assign quad    = quadrant_e'(addr[LUT_ADDR_W-1 -: 2]);
    assign fwd     = {1'b0, addr[IDX_W-1:0]};
    assign rev     = (IDX_W + 1)'(QN) - fwd;
    assign mag_fwd = rom[fwd];
    assign mag_rev = rom[rev];

    // Fold the first-quadrant magnitudes into the full circle.
    always_comb begin
        sin_d = '0;
        cos_d = '0;
        case (quad)
            Q0: begin sin_d =  mag_fwd; cos_d =  mag_rev; end
            Q1: begin sin_d =  mag_rev; cos_d = -mag_fwd; end
            Q2: begin sin_d = -mag_fwd; cos_d = -mag_rev; end
            Q3: begin sin_d = -mag_rev; cos_d =  mag_fwd; end
            default: begin sin_d = '0; cos_d = '0; end
        endcase
    end

    // S1 register: looked-up sine/cosine pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sin <= '0;
            cos <= '0;
        end else begin
            sin <= sin_d;
            cos <= cos_d;
        end
    end

endmodule

// File: rtl/carrier_nco_mixer.sv
// Carrier NCO and complex downconversion mixer for one tracking channel.
// Phase accumulator driven by NOMINAL_FCW + loop-filter correction, table
// lookup, multiply and round, plus an epoch tag for the integrate-and-dump.
// Build option NCO_DITHER_EN: adds LFSR dither below the table address.
//
// Handshake: there is no ready. A sample is accepted on every cycle with
// sample_valid high; each accepted sample yields exactly one out_valid pulse
// three cycles later (out_last qualifies it), and the consumer must take it.
module carrier_nco_mixer
    import nco_pkg::*;
#(
    parameter int                 PHASE_W     = DEF_PHASE_W,
    parameter int                 LUT_ADDR_W  = DEF_LUT_ADDR_W,
    parameter int                 LUT_W       = DEF_LUT_W,
    parameter logic [PHASE_W-1:0] NOMINAL_FCW = PHASE_W'(DEF_NOMINAL_FCW),
    parameter int                 EPOCH_LEN   = DEF_EPOCH_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LUT_W-1:0]   sample_in,
    input  logic               sample_valid,
    input  logic [PHASE_W-1:0] correction,
    input  logic               correction_valid,
    output logic [LUT_W-1:0]   out_i,
    output logic [LUT_W-1:0]   out_q,
    output logic               out_valid,
    output logic               out_last
);

    localparam int PROD_W = 2 * LUT_W;
    localparam int FRAC_W = PHASE_W - LUT_ADDR_W;
    localparam int EP_W   = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
    localparam logic [EP_W-1:0]          EP_LAST = EP_W'(EPOCH_LEN - 1);
    localparam logic signed [PROD_W-1:0] RND     = PROD_W'(round_const(LUT_W));

    logic [PHASE_W-1:0]       fcw;
    logic [PHASE_W-1:0]       phase;
    logic [PHASE_W-1:0]       addr_phase;
    logic [LUT_ADDR_W-1:0]    lut_addr;
    logic [EP_W-1:0]          ep_cnt;
    logic                     ep_wrap;
    logic signed [LUT_W-1:0]  lut_sin;
    logic signed [LUT_W-1:0]  lut_cos;
    logic signed [LUT_W-1:0]  s1_sample;
    logic                     s1_valid;
    logic                     s1_last;
    logic signed [PROD_W-1:0] s2_prod_i;
    logic signed [PROD_W-1:0] s2_prod_q;
    logic                     s2_valid;
    logic                     s2_last;
    logic signed [PROD_W-1:0] sum_i;
    logic signed [PROD_W-1:0] sum_q;

    // Frequency control word; a correction loaded together with a sample
    // only affects the increment of the following sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcw <= NOMINAL_FCW;
        end else if (correction_valid) begin
            fcw <= NOMINAL_FCW + correction;
        end
    end

    // Phase accumulator: the accepted sample is mixed with the current value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (sample_valid) begin
            phase <= phase + fcw;
        end
    end

    assign ep_wrap = (ep_cnt == EP_LAST);

    // Epoch counter over accepted samples; the wrapping sample is tagged last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ep_cnt <= '0;
        end else if (sample_valid) begin
            ep_cnt <= ep_wrap ? '0 : ep_cnt + EP_W'(1);
        end
    end

`ifdef NCO_DITHER_EN
    logic [15:0]        lfsr;
    logic [PHASE_W-1:0] dither;

    // Dither source, stepped once per accepted sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else if (sample_valid) begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
        end
    end

    assign dither     = PHASE_W'(lfsr) & ((PHASE_W'(1) << FRAC_W) - PHASE_W'(1));
    assign addr_phase = phase + dither;
`else
    assign addr_phase = phase;
`endif

    assign lut_addr = LUT_ADDR_W'(addr_phase >> FRAC_W);

    // The table is addressed straight from the pre-increment phase, so the
    // S0 capture and the S1 lookup land on the same clock edge.
    nco_sincos_lut #(
        .LUT_ADDR_W (LUT_ADDR_W),
        .LUT_W      (LUT_W)
    ) u_lut (
        .clk  (clk),
        .rst  (rst),
        .addr (lut_addr),
        .sin  (lut_sin),
        .cos  (lut_cos)
    );

    // S0: capture the sample and its epoch tag alongside the lookup.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_sample <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
        end else begin
            s1_valid <= sample_valid;
            s1_last  <= sample_valid & ep_wrap;
            if (sample_valid) begin
                s1_sample <= sample_in;
            end
        end
    end

    // S2: full-precision products; Q is negated for e^{-j*phase}.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_prod_i <= '0;
            s2_prod_q <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                s2_prod_i <= PROD_W'(s1_sample) * PROD_W'(lut_cos);
                s2_prod_q <= -(PROD_W'(s1_sample) * PROD_W'(lut_sin));
            end
        end
    end

    // Magnitudes never exceed full scale, so the rounded result fits LUT_W.
    assign sum_i = s2_prod_i + RND;
    assign sum_q = s2_prod_q + RND;

    // S3: round, drop fraction bits and register the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= s2_valid;
            out_last  <= s2_last;
            if (s2_valid) begin
                out_i <= LUT_W'(sum_i >>> (LUT_W - 1));
                out_q <= LUT_W'(sum_q >>> (LUT_W - 1));
            end
        end
    end

endmodule

// File: tb/tb_carrier_nco_mixer.sv
// Self-checking bench for carrier_nco_mixer (default build, no dither).
// Stimulus keeps every phase on a quarter-cycle so sin/cos are exact.
module tb_carrier_nco_mixer;

  localparam int          EP  = 5;
  localparam logic [31:0] NOM = 32'h4000_0000;
  localparam logic [31:0] QTR = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [31:0] correction = '0;
  logic        correction_valid = 1'b0;
  logic [15:0] out_i;
  logic [15:0] out_q;
  logic        out_valid;
  logic        out_last;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Scoreboard: {last, i, q} plus the cycle each sample was driven.
  logic [32:0] exp_q[$];
  int          lat_q[$];
  logic [32:0] exp_w;
  int          t0;

  // Reference model state.
  logic [31:0] m_phase;
  logic [31:0] m_fcw;
  int          m_ep;
  int          out_count;
  logic [31:0] last_mask;

  carrier_nco_mixer #(.EPOCH_LEN(EP)) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .correction       (correction),
    .correction_valid (correction_valid),
    .out_i            (out_i),
    .out_q            (out_q),
    .out_valid        (out_valid),
    .out_last         (out_last)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Expected output for sample s mixed at a quarter-cycle phase.
  function automatic logic [32:0] exp_word(input logic [15:0] s, input logic [31:0] ph,
                                           input logic last);
    longint sv;
    longint c;
    longint sn;
    longint ri;
    longint rq;
    sv = longint'($signed(s));
    case (ph[31:30])
      2'd0: begin c =  32767; sn =      0; end
      2'd1: begin c =      0; sn =  32767; end
      2'd2: begin c = -32767; sn =      0; end
      default: begin c = 0; sn = -32767; end
    endcase
    ri = (sv * c + 16384) >>> 15;
    rq = (-(sv * sn) + 16384) >>> 15;
    return {last, ri[15:0], rq[15:0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    lat_q.delete();
    m_phase   = '0;
    m_fcw     = NOM;
    m_ep      = 0;
    out_count = 0;
    last_mask = '0;
  endtask

  // ---------------- driver tasks ----------------
  // Called on a falling edge; holds the inputs for one rising edge.
  task automatic drive(input logic sv, input logic [15:0] s, input logic cv,
                       input logic [31:0] corr);
    logic last;
    sample_valid     = sv;
    sample_in        = s;
    correction_valid = cv;
    correction       = corr;
    if (sv) begin
      last = (m_ep == EP - 1);
      exp_q.push_back(exp_word(s, m_phase, last));
      lat_q.push_back(cyc);
      m_phase = m_phase + m_fcw;
      m_ep    = last ? 0 : m_ep + 1;
    end
    if (cv) m_fcw = NOM + corr;
    @(negedge clk);
    sample_valid     = 1'b0;
    correction_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    sample_valid = 1'b0;
    correction_valid = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d outputs missing after %0d cycles, required 0",
               exp_q.size(), n);
      exp_q.delete();
      lat_q.delete();
    end
    idle(3);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst && out_valid) begin
      out_count = out_count + 1;
      if (out_last && out_count < 32) last_mask[out_count] = 1'b1;
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_output: got i=%0d q=%0d last=%0b, required no output",
                 $signed(out_i), $signed(out_q), out_last);
      end else begin
        exp_w = exp_q.pop_front();
        t0    = lat_q.pop_front();
        if ({out_last, out_i, out_q} !== exp_w) begin
          bad = bad + 1;
          $display("FAIL mix_output #%0d: got i=%0d q=%0d last=%0b, required i=%0d q=%0d last=%0b",
                   out_count, $signed(out_i), $signed(out_q), out_last,
                   $signed(exp_w[31:16]), $signed(exp_w[15:0]), exp_w[32]);
        end
        total = total + 1;
        if (cyc - t0 !== 3) begin
          bad = bad + 1;
          $display("FAIL latency #%0d: got %0d cycles, required 3", out_count, cyc - t0);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    total++;
    if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b, required 0", out_last); end
    idle(3);
    total++;
    if (out_i !== 16'd0) begin bad++; $display("FAIL reset_i: got %h, required 0000", out_i); end
    total++;
    if (out_q !== 16'd0) begin bad++; $display("FAIL reset_q: got %h, required 0000", out_q); end
    rst = 1'b1;
    // Second sample lands on a quarter turn only if fcw came out of reset nominal.
    drive(1'b1, 16'd1000, 1'b0, '0);
    drive(1'b1, 16'd1000, 1'b0, '0);
    drain();
  endtask

  task automatic test_quarter_rotation();
    apply_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd1000, 1'b0, '0);
    drain();
  endtask

  task automatic test_extremes();
    apply_reset();
    // Zero frequency: every sample is mixed at phase 0.
    drive(1'b0, '0, 1'b1, -QTR);
    drive(1'b1, 16'h8000, 1'b0, '0);
    drive(1'b1, 16'd16384, 1'b0, '0);
    drive(1'b1, 16'h7FFF, 1'b0, '0);
    drive(1'b1, 16'hFFFF, 1'b0, '0);
    drive(1'b1, 16'd1, 1'b0, '0);
    // Back to nominal: full-scale negative sample through all four quadrants.
    drive(1'b0, '0, 1'b1, '0);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h8000, 1'b0, '0);
    drain();
  endtask

  task automatic test_correction_timing();
    apply_reset();
    drive(1'b1, 16'd1000, 1'b0, '0);
    drive(1'b1, 16'd1000, 1'b0, '0);
    drive(1'b1, 16'd1000, 1'b1, -QTR);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'($urandom_range(0, 65535)), 1'b0, '0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic        sv;
    logic        cv;
    logic [31:0] corr;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      sv   = ($urandom_range(0, 3) != 0);
      cv   = ($urandom_range(0, 4) == 0);
      corr = 32'($urandom_range(0, 3)) << 30;
      drive(sv, 16'($urandom_range(0, 65535)), cv, corr);
    end
    drain();
  endtask

  task automatic test_epoch();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 16'($urandom_range(0, 65535)), 1'b0, '0);
      idle(int'($urandom_range(0, 2)));
    end
    drain();
    total++;
    if (last_mask !== 32'h0000_0420) begin
      bad++;
      $display("FAIL epoch_last_positions: got mask %h, required 00000420", last_mask);
    end
    total++;
    if (out_count !== 12) begin
      bad++;
      $display("FAIL epoch_count: got %0d outputs, required 12", out_count);
    end
  endtask

  task automatic test_midstream_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 16'd1000, 1'b0, '0);
    drain();
    drive(1'b1, 16'd3000, 1'b0, '0);
    drive(1'b1, 16'd3000, 1'b0, '0);
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b, required 0", out_valid); end
    total++;
    if (out_i !== 16'd0) begin bad++; $display("FAIL midreset_i: got %0d, required 0", $signed(out_i)); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midreset_hold: got valid=%b in reset cycle %0d, required 0", out_valid, i);
      end
    end
    rst = 1'b1;
    idle(4);
    for (int i = 0; i < 5; i++) drive(1'b1, 16'(500 * (i + 1)), 1'b0, '0);
    drain();
    total++;
    if (last_mask !== 32'h0000_0020) begin
      bad++;
      $display("FAIL midreset_epoch: got mask %h, required 00000020", last_mask);
    end
    total++;
    if (out_count !== 5) begin
      bad++;
      $display("FAIL midreset_count: got %0d outputs, required 5", out_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_quarter_rotation();
    test_extremes();
    test_correction_timing();
    test_back_to_back();
    test_epoch();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
